// File: rtl/cache_l2_fa.sv
// cache_l2_fa: second-level cache behind the write-through L1.
// 8-entry fully associative array of 16-bit words, write-back with
// write-allocate and true-LRU replacement. Misses and dirty evictions go to
// main memory over a level req / one-cycle ack handshake.
// Optional feature: define L2_STATS_EN to add saturating hit_cnt/miss_cnt.
module cache_l2_fa #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_ENT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ack,
    output logic              hit,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef L2_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_ENT);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_ENT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEvict,
        StFill,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Cache array
    logic [NUM_ENT-1:0] valid_q;
    logic [NUM_ENT-1:0] dirty_q;
    logic [ADDR_W-1:0]  tag_q  [NUM_ENT];
    logic [DATA_W-1:0]  data_q [NUM_ENT];
    logic [IDX_W-1:0]   age_q  [NUM_ENT];
    logic [IDX_W-1:0]   age_d  [NUM_ENT];

    // Latched request
    logic              req_wren_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;

    // Response and memory-side registers
    logic              hit_q;
    logic [DATA_W-1:0] q_q;
    logic [IDX_W-1:0]  victim_q;
    logic              mem_req_q;
    logic              mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Lookup / victim results
    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic              inv_any;
    logic [IDX_W-1:0]  inv_idx;
    logic [IDX_W-1:0]  old_idx;
    logic [IDX_W-1:0]  victim;
    logic              need_evict;

    // Entry write port and LRU touch
    logic              ent_we;
    logic [IDX_W-1:0]  ent_idx;
    logic [DATA_W-1:0] ent_data;
    logic              ent_dirty;
    logic              clr_dirty;
    logic              touch;
    logic [IDX_W-1:0]  touch_idx;

    // Parallel tag compare against all valid entries
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: lowest-index invalid entry, else the entry with the oldest age
    always_comb begin
        inv_any = 1'b0;
        inv_idx = '0;
        old_idx = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENT; i++) begin
            if (age_q[i] == AGE_MAX) begin
                old_idx = IDX_W'(i);
            end
        end
        victim     = inv_any ? inv_idx : old_idx;
        need_evict = valid_q[victim] && dirty_q[victim];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit_any) begin
                    state_d = StResp;
                end else if (need_evict) begin
                    state_d = StEvict;
                end else if (req_wren_q) begin
                    state_d = StResp;
                end else begin
                    state_d = StFill;
                end
            end
            StEvict: begin
                if (mem_ack) begin
                    state_d = req_wren_q ? StResp : StFill;
                end
            end
            StFill: begin
                if (mem_ack) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs; ack and hit exist only in the response cycle
    always_comb begin
        ack  = (state_q == StResp);
        hit  = (state_q == StResp) && hit_q;
        busy = (state_q != StIdle);
    end

    assign q         = q_q;
    assign mem_req   = mem_req_q;
    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Decide which entry is written / touched this cycle
    always_comb begin
        ent_we    = 1'b0;
        ent_idx   = victim_q;
        ent_data  = req_data_q;
        ent_dirty = 1'b1;
        clr_dirty = 1'b0;
        touch     = 1'b0;
        touch_idx = victim_q;
        case (state_q)
            StLookup: begin
                if (hit_any) begin
                    touch     = 1'b1;
                    touch_idx = hit_idx;
                    if (req_wren_q) begin
                        ent_we  = 1'b1;
                        ent_idx = hit_idx;
                    end
                end else if (!need_evict && req_wren_q) begin
                    // Write miss into a clean or empty slot installs at once
                    ent_we    = 1'b1;
                    ent_idx   = victim;
                    touch     = 1'b1;
                    touch_idx = victim;
                end
            end
            StEvict: begin
                if (mem_ack) begin
                    clr_dirty = 1'b1;
                    if (req_wren_q) begin
                        ent_we = 1'b1;
                        touch  = 1'b1;
                    end
                end
            end
            StFill: begin
                if (mem_ack) begin
                    ent_we    = 1'b1;
                    ent_data  = mem_rdata;
                    ent_dirty = 1'b0;
                    touch     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // True-LRU: younger-than-touched entries age by one, touched entry becomes 0
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            age_d[i] = age_q[i];
        end
        if (touch) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    // Cache array update
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
        end else begin
            if (clr_dirty) begin
                dirty_q[victim_q] <= 1'b0;
            end
            if (ent_we) begin
                valid_q[ent_idx] <= 1'b1;
                dirty_q[ent_idx] <= ent_dirty;
                tag_q[ent_idx]   <= req_addr_q;
                data_q[ent_idx]  <= ent_data;
            end
            for (int i = 0; i < NUM_ENT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Capture the request while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            req_wren_q <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else if ((state_q == StIdle) && req) begin
            req_wren_q <= wren;
            req_addr_q <= addr;
            req_data_q <= data;
        end
    end

    // Response data, hit flag and victim latch
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q    <= 1'b0;
            q_q      <= '0;
            victim_q <= '0;
        end else begin
            if (state_q == StLookup) begin
                hit_q    <= hit_any;
                victim_q <= victim;
            end
            // Every entry write also carries the word returned to the L1
            if (ent_we) begin
                q_q <= ent_data;
            end else if ((state_q == StLookup) && hit_any) begin
                q_q <= data_q[hit_idx];
            end
        end
    end

    // Memory request: high while in EVICT/FILL; fields load on entry
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_req_q <= (state_d == StEvict) || (state_d == StFill);
            if ((state_q == StLookup) && (state_d == StEvict)) begin
                mem_wren_q  <= 1'b1;
                mem_addr_q  <= tag_q[victim];
                mem_wdata_q <= data_q[victim];
            end else if ((state_d == StFill) && (state_q != StFill)) begin
                mem_wren_q <= 1'b0;
                mem_addr_q <= req_addr_q;
            end
        end
    end

`ifdef L2_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // Saturating hit/miss counters, stepped in the response cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StResp) begin
            if (hit_q) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                end
            end else begin
                if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_cache_l2_fa.sv
// Directed bench for cache_l2_fa: a small memory model answers mem_req after a
// fixed latency; expected values are hand-computed from the cache contents.
module tb_cache_l2_fa;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [6:0]  addr = '0;
    logic [15:0] data = '0;
    logic        ack;
    logic        hit;
    logic [15:0] q;
    logic        busy;
    logic        mem_req;
    logic        mem_wren;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef L2_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem_model [128];
    logic        log_wr    [4];
    logic [6:0]  log_addr  [4];
    logic [15:0] log_wdata [4];
    int          n_log;

    logic        r_done;
    logic        r_hit;
    logic [15:0] r_q;
    int          r_cyc;

    cache_l2_fa dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wren      (wren),
        .addr      (addr),
        .data      (data),
        .ack       (ack),
        .hit       (hit),
        .q         (q),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef L2_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One L1 request; services memory and records the response cycle
    task automatic xact(input logic wr, input logic [6:0] a, input logic [15:0] d);
        int lat;
        @(negedge clk);
        req    = 1'b1;
        wren   = wr;
        addr   = a;
        data   = d;
        r_done = 1'b0;
        r_hit  = 1'b0;
        r_q    = '0;
        r_cyc  = 0;
        n_log  = 0;
        lat    = 0;
        while (!r_done && r_cyc < 100) begin
            @(negedge clk);
            r_cyc++;
            mem_ack = 1'b0;
            if (ack) begin
                r_done = 1'b1;
                r_hit  = hit;
                r_q    = q;
                req    = 1'b0;
            end else if (mem_req) begin
                if (lat == MEM_LAT) begin
                    if (n_log < 4) begin
                        log_wr[n_log]    = mem_wren;
                        log_addr[n_log]  = mem_addr;
                        log_wdata[n_log] = mem_wdata;
                    end
                    n_log++;
                    if (mem_wren) mem_model[mem_addr] = mem_wdata;
                    else          mem_rdata = mem_model[mem_addr];
                    mem_ack = 1'b1;
                    lat     = 0;
                end else begin
                    lat++;
                end
            end
        end
        req = 1'b0;
        chk("xact_done", {31'd0, r_done}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        reset = 1'b0;

        // Stray mem_ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_memreq", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_q", {16'd0, q}, 32'd0);

        // Read miss 05, memory returns BEEF
        mem_model[7'h05] = 16'hBEEF;
        xact(1'b0, 7'h05, 16'h0000);
        chk("rd05_hit", {31'd0, r_hit}, 32'd0);
        chk("rd05_q", {16'd0, r_q}, 32'h0000BEEF);
        chk("rd05_nmem", n_log, 32'd1);
        chk("rd05_mem_wr", {31'd0, log_wr[0]}, 32'd0);
        chk("rd05_mem_addr", {25'd0, log_addr[0]}, 32'h05);
        chk("rd05_cyc", r_cyc, 32'd5);

        // Re-read 05 hits in the 3rd cycle without memory traffic
        xact(1'b0, 7'h05, 16'h0000);
        chk("rr05_hit", {31'd0, r_hit}, 32'd1);
        chk("rr05_q", {16'd0, r_q}, 32'h0000BEEF);
        chk("rr05_cyc", r_cyc, 32'd2);
        chk("rr05_nmem", n_log, 32'd0);

        // Write hit on 05, then read it back
        xact(1'b1, 7'h05, 16'h9999);
        chk("wh05_hit", {31'd0, r_hit}, 32'd1);
        chk("wh05_q", {16'd0, r_q}, 32'h00009999);
        xact(1'b0, 7'h05, 16'h0000);
        chk("wh05_rd_q", {16'd0, r_q}, 32'h00009999);

        // Write miss 10 installs into an empty slot
        xact(1'b1, 7'h10, 16'h1234);
        chk("wm10_hit", {31'd0, r_hit}, 32'd0);
        chk("wm10_q", {16'd0, r_q}, 32'h00001234);
        chk("wm10_nmem", n_log, 32'd0);
        chk("wm10_cyc", r_cyc, 32'd2);
        xact(1'b0, 7'h10, 16'h0000);
        chk("rd10_hit", {31'd0, r_hit}, 32'd1);
        chk("rd10_q", {16'd0, r_q}, 32'h00001234);

        // Fill all eight entries, touch addr 0, then write 08 evicting addr 1
        do_reset();
        for (int i = 0; i < 8; i++) xact(1'b1, 7'(i), 16'h0100 + 16'(i));
        xact(1'b0, 7'h00, 16'h0000);
        chk("rd00_hit", {31'd0, r_hit}, 32'd1);
        xact(1'b1, 7'h08, 16'h0808);
        chk("w08_hit", {31'd0, r_hit}, 32'd0);
        chk("w08_q", {16'd0, r_q}, 32'h00000808);
        chk("w08_nmem", n_log, 32'd1);
        chk("w08_ev_wr", {31'd0, log_wr[0]}, 32'd1);
        chk("w08_ev_addr", {25'd0, log_addr[0]}, 32'h01);
        chk("w08_ev_data", {16'd0, log_wdata[0]}, 32'h00000101);
        chk("w08_cyc", r_cyc, 32'd5);
        chk("w08_memreq_drop", {31'd0, mem_req}, 32'd0);
        xact(1'b0, 7'h00, 16'h0000);
        chk("rd00b_hit", {31'd0, r_hit}, 32'd1);
        chk("rd00b_q", {16'd0, r_q}, 32'h00000100);

        // Read miss 20 evicts dirty addr 2, then fills
        mem_model[7'h20] = 16'hCAFE;
        xact(1'b0, 7'h20, 16'h0000);
        chk("rd20_hit", {31'd0, r_hit}, 32'd0);
        chk("rd20_q", {16'd0, r_q}, 32'h0000CAFE);
        chk("rd20_nmem", n_log, 32'd2);
        chk("rd20_m0_wr", {31'd0, log_wr[0]}, 32'd1);
        chk("rd20_m0_addr", {25'd0, log_addr[0]}, 32'h02);
        chk("rd20_m0_data", {16'd0, log_wdata[0]}, 32'h00000102);
        chk("rd20_m1_wr", {31'd0, log_wr[1]}, 32'd0);
        chk("rd20_m1_addr", {25'd0, log_addr[1]}, 32'h20);
        chk("rd20_cyc", r_cyc, 32'd8);

        // Reset during FILL with mem_ack arriving at the same edge
        do_reset();
        @(negedge clk);
        req  = 1'b1;
        wren = 1'b0;
        addr = 7'h30;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("fill_memreq", {31'd0, mem_req}, 32'd1);
        chk("fill_mem_addr", {25'd0, mem_addr}, 32'h30);
        chk("fill_mem_wren", {31'd0, mem_wren}, 32'd0);
        chk("fill_busy", {31'd0, busy}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        reset     = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_hit", {31'd0, hit}, 32'd0);
        chk("abort_q", {16'd0, q}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_memreq", {31'd0, mem_req}, 32'd0);
        chk("abort_mem_addr", {25'd0, mem_addr}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        chk("late_ack_memreq", {31'd0, mem_req}, 32'd0);
        mem_model[7'h30] = 16'h5A5A;
        xact(1'b0, 7'h30, 16'h0000);
        chk("rd30_hit", {31'd0, r_hit}, 32'd0);
        chk("rd30_nmem", n_log, 32'd1);
        chk("rd30_q", {16'd0, r_q}, 32'h00005A5A);

`ifdef L2_STATS_EN
        // Three hits and two misses from a clean start
        do_reset();
        mem_model[7'h10] = 16'h0010;
        xact(1'b0, 7'h05, 16'h0000);
        xact(1'b0, 7'h05, 16'h0000);
        xact(1'b1, 7'h05, 16'h4444);
        xact(1'b0, 7'h10, 16'h0000);
        xact(1'b0, 7'h10, 16'h0000);
        @(negedge clk);
        chk("hit_cnt", {16'd0, hit_cnt}, 32'd3);
        chk("miss_cnt", {16'd0, miss_cnt}, 32'd2);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        xact(1'b0, 7'h10, 16'h0000);
        @(negedge clk);
        chk("hit_cnt_sat", {16'd0, hit_cnt}, 32'h0000FFFF);
        chk("miss_cnt_hold", {16'd0, miss_cnt}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
